// File: rtl/sd_axil_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sd_axil_arbiter
//  Purpose  : Two-port AXI4-Lite arbiter in front of the SD card reader slave.
//             One transaction is in flight at a time. Port 0 (CPU) and
//             port 1 (loader/DMA) compete in IDLE. The winner's request is
//             captured, replayed on the master port (AW strictly before W),
//             and the response is handed back to the winner only.
//  Ports    : aclk, aresetn             - clock, synchronous active-low reset
//             s0_axil_* / s1_axil_*     - AXI4-Lite slave ports 0 and 1
//             m_axil_*                  - AXI4-Lite master port to SD reader
//  Params   : PRIO_FIXED  0 = round-robin on conflicts, 1 = port 0 always wins
//  Revision : 1.0  initial release
// ============================================================================
module sd_axil_arbiter #(
  parameter int PRIO_FIXED = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  // slave port 0
  input  logic [31:0] s0_axil_awaddr,
  input  logic [2:0]  s0_axil_awprot,
  input  logic        s0_axil_awvalid,
  output logic        s0_axil_awready,
  input  logic [31:0] s0_axil_wdata,
  input  logic [3:0]  s0_axil_wstrb,
  input  logic        s0_axil_wvalid,
  output logic        s0_axil_wready,
  output logic [1:0]  s0_axil_bresp,
  output logic        s0_axil_bvalid,
  input  logic        s0_axil_bready,
  input  logic [31:0] s0_axil_araddr,
  input  logic [2:0]  s0_axil_arprot,
  input  logic        s0_axil_arvalid,
  output logic        s0_axil_arready,
  output logic [31:0] s0_axil_rdata,
  output logic [1:0]  s0_axil_rresp,
  output logic        s0_axil_rvalid,
  input  logic        s0_axil_rready,
  // slave port 1
  input  logic [31:0] s1_axil_awaddr,
  input  logic [2:0]  s1_axil_awprot,
  input  logic        s1_axil_awvalid,
  output logic        s1_axil_awready,
  input  logic [31:0] s1_axil_wdata,
  input  logic [3:0]  s1_axil_wstrb,
  input  logic        s1_axil_wvalid,
  output logic        s1_axil_wready,
  output logic [1:0]  s1_axil_bresp,
  output logic        s1_axil_bvalid,
  input  logic        s1_axil_bready,
  input  logic [31:0] s1_axil_araddr,
  input  logic [2:0]  s1_axil_arprot,
  input  logic        s1_axil_arvalid,
  output logic        s1_axil_arready,
  output logic [31:0] s1_axil_rdata,
  output logic [1:0]  s1_axil_rresp,
  output logic        s1_axil_rvalid,
  input  logic        s1_axil_rready,
  // master port
  output logic [31:0] m_axil_awaddr,
  output logic [2:0]  m_axil_awprot,
  output logic        m_axil_awvalid,
  input  logic        m_axil_awready,
  output logic [31:0] m_axil_wdata,
  output logic [3:0]  m_axil_wstrb,
  output logic        m_axil_wvalid,
  input  logic        m_axil_wready,
  input  logic [1:0]  m_axil_bresp,
  input  logic        m_axil_bvalid,
  output logic        m_axil_bready,
  output logic [31:0] m_axil_araddr,
  output logic [2:0]  m_axil_arprot,
  output logic        m_axil_arvalid,
  input  logic        m_axil_arready,
  input  logic [31:0] m_axil_rdata,
  input  logic [1:0]  m_axil_rresp,
  input  logic        m_axil_rvalid,
  output logic        m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_AW  = 3'd1,
    WR_W   = 3'd2,
    WR_B   = 3'd3,
    WR_RSP = 3'd4,
    RD_AR  = 3'd5,
    RD_R   = 3'd6,
    RD_RSP = 3'd7
  } state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic        r_owner;
  logic [31:0] r_addr;
  logic [2:0]  r_prot;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  // A write needs both AW and W valid; a lone AW or W is not a request.
  logic w_wr0, w_wr1, w_req0, w_req1;
  logic w_winner, w_win_wr, w_grant;
  logic w_bready_sel, w_rready_sel;

  assign w_wr0  = s0_axil_awvalid & s0_axil_wvalid;
  assign w_wr1  = s1_axil_awvalid & s1_axil_wvalid;
  assign w_req0 = w_wr0 | s0_axil_arvalid;
  assign w_req1 = w_wr1 | s1_axil_arvalid;

  // On a conflict the port that did not win last time is served, unless
  // fixed priority is selected, in which case port 0 always wins.
  always_comb begin
    w_winner = 1'b0;
    if (w_req0 && w_req1) begin
      w_winner = (PRIO_FIXED != 0) ? 1'b0 : ~r_last_grant;
    end else if (w_req1) begin
      w_winner = 1'b1;
    end
  end

  assign w_win_wr = w_winner ? w_wr1 : w_wr0;
  // Gated by aresetn so no handshake completes during a reset cycle.
  assign w_grant  = aresetn && (r_state == IDLE) && (w_req0 || w_req1);

  assign s0_axil_awready = w_grant & ~w_winner &  w_win_wr;
  assign s0_axil_wready  = w_grant & ~w_winner &  w_win_wr;
  assign s0_axil_arready = w_grant & ~w_winner & ~w_win_wr;
  assign s1_axil_awready = w_grant &  w_winner &  w_win_wr;
  assign s1_axil_wready  = w_grant &  w_winner &  w_win_wr;
  assign s1_axil_arready = w_grant &  w_winner & ~w_win_wr;

  assign w_bready_sel = r_owner ? s1_axil_bready : s0_axil_bready;
  assign w_rready_sel = r_owner ? s1_axil_rready : s0_axil_rready;

  // Captured payload is replayed unmodified on the master side.
  assign m_axil_awaddr = r_addr;
  assign m_axil_awprot = r_prot;
  assign m_axil_araddr = r_addr;
  assign m_axil_arprot = r_prot;
  assign m_axil_wdata  = r_wdata;
  assign m_axil_wstrb  = r_wstrb;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state        <= IDLE;
      r_last_grant   <= 1'b1;
      r_owner        <= 1'b0;
      r_addr         <= '0;
      r_prot         <= '0;
      r_wdata        <= '0;
      r_wstrb        <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      s0_axil_bvalid <= 1'b0;
      s0_axil_bresp  <= '0;
      s0_axil_rvalid <= 1'b0;
      s0_axil_rdata  <= '0;
      s0_axil_rresp  <= '0;
      s1_axil_bvalid <= 1'b0;
      s1_axil_bresp  <= '0;
      s1_axil_rvalid <= 1'b0;
      s1_axil_rdata  <= '0;
      s1_axil_rresp  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner      <= w_winner;
            r_last_grant <= w_winner;
            if (w_win_wr) begin
              r_addr         <= w_winner ? s1_axil_awaddr : s0_axil_awaddr;
              r_prot         <= w_winner ? s1_axil_awprot : s0_axil_awprot;
              r_wdata        <= w_winner ? s1_axil_wdata  : s0_axil_wdata;
              r_wstrb        <= w_winner ? s1_axil_wstrb  : s0_axil_wstrb;
              m_axil_awvalid <= 1'b1;
              r_state        <= WR_AW;
            end else begin
              r_addr         <= w_winner ? s1_axil_araddr : s0_axil_araddr;
              r_prot         <= w_winner ? s1_axil_arprot : s0_axil_arprot;
              m_axil_arvalid <= 1'b1;
              r_state        <= RD_AR;
            end
          end
        end
        // The reader refuses W while AW is pending, so AW completes first.
        WR_AW: begin
          if (m_axil_awready) begin
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b1;
            r_state        <= WR_W;
          end
        end
        WR_W: begin
          if (m_axil_wready) begin
            m_axil_wvalid <= 1'b0;
            m_axil_bready <= 1'b1;
            r_state       <= WR_B;
          end
        end
        WR_B: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            if (r_owner) begin
              s1_axil_bvalid <= 1'b1;
              s1_axil_bresp  <= m_axil_bresp;
            end else begin
              s0_axil_bvalid <= 1'b1;
              s0_axil_bresp  <= m_axil_bresp;
            end
            r_state <= WR_RSP;
          end
        end
        WR_RSP: begin
          if (w_bready_sel) begin
            s0_axil_bvalid <= 1'b0;
            s1_axil_bvalid <= 1'b0;
            s0_axil_bresp  <= '0;
            s1_axil_bresp  <= '0;
            r_state        <= IDLE;
          end
        end
        RD_AR: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            r_state        <= RD_R;
          end
        end
        RD_R: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            if (r_owner) begin
              s1_axil_rvalid <= 1'b1;
              s1_axil_rdata  <= m_axil_rdata;
              s1_axil_rresp  <= m_axil_rresp;
            end else begin
              s0_axil_rvalid <= 1'b1;
              s0_axil_rdata  <= m_axil_rdata;
              s0_axil_rresp  <= m_axil_rresp;
            end
            r_state <= RD_RSP;
          end
        end
        RD_RSP: begin
          if (w_rready_sel) begin
            s0_axil_rvalid <= 1'b0;
            s1_axil_rvalid <= 1'b0;
            s0_axil_rdata  <= '0;
            s1_axil_rdata  <= '0;
            s0_axil_rresp  <= '0;
            s1_axil_rresp  <= '0;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_axil_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_axil_arbiter
//  Purpose  : Directed self-checking bench for sd_axil_arbiter. Instance dut
//             (round-robin) talks to a latency-configurable reader model;
//             instance dut_fx (fixed priority) talks to an always-ready one.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sd_axil_arbiter;
  localparam int LIMIT = 8000;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // slave-side stimulus for dut, index = port
  logic [1:0][31:0] aw_addr, w_data, ar_addr;
  logic [1:0][2:0]  aw_prot, ar_prot;
  logic [1:0][3:0]  w_strb;
  logic [1:0]       aw_valid, w_valid, b_ready, ar_valid, r_ready;
  wire  [1:0]       s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  wire  [1:0][1:0]  s_bresp, s_rresp;
  wire  [1:0][31:0] s_rdata;

  wire [31:0] m_awaddr, m_wdata, m_araddr;
  wire [2:0]  m_awprot, m_arprot;
  wire [3:0]  m_wstrb;
  wire        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic       m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0] m_bresp, m_rresp;
  logic [31:0] m_rdata;

  sd_axil_arbiter #(.PRIO_FIXED(0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axil_awaddr(aw_addr[0]), .s0_axil_awprot(aw_prot[0]), .s0_axil_awvalid(aw_valid[0]), .s0_axil_awready(s_awready[0]),
    .s0_axil_wdata(w_data[0]), .s0_axil_wstrb(w_strb[0]), .s0_axil_wvalid(w_valid[0]), .s0_axil_wready(s_wready[0]),
    .s0_axil_bresp(s_bresp[0]), .s0_axil_bvalid(s_bvalid[0]), .s0_axil_bready(b_ready[0]),
    .s0_axil_araddr(ar_addr[0]), .s0_axil_arprot(ar_prot[0]), .s0_axil_arvalid(ar_valid[0]), .s0_axil_arready(s_arready[0]),
    .s0_axil_rdata(s_rdata[0]), .s0_axil_rresp(s_rresp[0]), .s0_axil_rvalid(s_rvalid[0]), .s0_axil_rready(r_ready[0]),
    .s1_axil_awaddr(aw_addr[1]), .s1_axil_awprot(aw_prot[1]), .s1_axil_awvalid(aw_valid[1]), .s1_axil_awready(s_awready[1]),
    .s1_axil_wdata(w_data[1]), .s1_axil_wstrb(w_strb[1]), .s1_axil_wvalid(w_valid[1]), .s1_axil_wready(s_wready[1]),
    .s1_axil_bresp(s_bresp[1]), .s1_axil_bvalid(s_bvalid[1]), .s1_axil_bready(b_ready[1]),
    .s1_axil_araddr(ar_addr[1]), .s1_axil_arprot(ar_prot[1]), .s1_axil_arvalid(ar_valid[1]), .s1_axil_arready(s_arready[1]),
    .s1_axil_rdata(s_rdata[1]), .s1_axil_rresp(s_rresp[1]), .s1_axil_rvalid(s_rvalid[1]), .s1_axil_rready(r_ready[1]),
    .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
    .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
    .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
    .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
    .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
  );

  // fixed-priority instance: reads only, always-ready reader
  logic [1:0]       p_arvalid, p_rready;
  wire  [1:0]       p_awready, p_wready, p_bvalid, p_arready, p_rvalid;
  wire  [1:0][1:0]  p_bresp, p_rresp;
  wire  [1:0][31:0] p_rdata;
  wire [31:0] p_m_awaddr, p_m_wdata, p_m_araddr;
  wire [2:0]  p_m_awprot, p_m_arprot;
  wire [3:0]  p_m_wstrb;
  wire        p_m_awvalid, p_m_wvalid, p_m_bready, p_m_arvalid, p_m_rready;

  sd_axil_arbiter #(.PRIO_FIXED(1)) dut_fx (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axil_awaddr(32'd0), .s0_axil_awprot(3'd0), .s0_axil_awvalid(1'b0), .s0_axil_awready(p_awready[0]),
    .s0_axil_wdata(32'd0), .s0_axil_wstrb(4'd0), .s0_axil_wvalid(1'b0), .s0_axil_wready(p_wready[0]),
    .s0_axil_bresp(p_bresp[0]), .s0_axil_bvalid(p_bvalid[0]), .s0_axil_bready(1'b1),
    .s0_axil_araddr(32'd0), .s0_axil_arprot(3'd0), .s0_axil_arvalid(p_arvalid[0]), .s0_axil_arready(p_arready[0]),
    .s0_axil_rdata(p_rdata[0]), .s0_axil_rresp(p_rresp[0]), .s0_axil_rvalid(p_rvalid[0]), .s0_axil_rready(p_rready[0]),
    .s1_axil_awaddr(32'd0), .s1_axil_awprot(3'd0), .s1_axil_awvalid(1'b0), .s1_axil_awready(p_awready[1]),
    .s1_axil_wdata(32'd0), .s1_axil_wstrb(4'd0), .s1_axil_wvalid(1'b0), .s1_axil_wready(p_wready[1]),
    .s1_axil_bresp(p_bresp[1]), .s1_axil_bvalid(p_bvalid[1]), .s1_axil_bready(1'b1),
    .s1_axil_araddr(32'd0), .s1_axil_arprot(3'd0), .s1_axil_arvalid(p_arvalid[1]), .s1_axil_arready(p_arready[1]),
    .s1_axil_rdata(p_rdata[1]), .s1_axil_rresp(p_rresp[1]), .s1_axil_rvalid(p_rvalid[1]), .s1_axil_rready(p_rready[1]),
    .m_axil_awaddr(p_m_awaddr), .m_axil_awprot(p_m_awprot), .m_axil_awvalid(p_m_awvalid), .m_axil_awready(1'b1),
    .m_axil_wdata(p_m_wdata), .m_axil_wstrb(p_m_wstrb), .m_axil_wvalid(p_m_wvalid), .m_axil_wready(1'b1),
    .m_axil_bresp(2'd0), .m_axil_bvalid(1'b1), .m_axil_bready(p_m_bready),
    .m_axil_araddr(p_m_araddr), .m_axil_arprot(p_m_arprot), .m_axil_arvalid(p_m_arvalid), .m_axil_arready(1'b1),
    .m_axil_rdata(32'd0), .m_axil_rresp(2'd0), .m_axil_rvalid(1'b1), .m_axil_rready(p_m_rready)
  );

  // ---------------- reader model for dut ----------------
  int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0] bresp_v = 2'd0, rresp_v = 2'd0;
  logic [31:0] rd_addr;

  initial begin
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
    m_bresp = 0; m_rresp = 0; m_rdata = 0; rd_addr = 0;
    forever begin
      @(posedge aclk); #1;
      m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
      m_bresp = 0; m_rresp = 0; m_rdata = 0;
      if (!aresetn) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      end else begin
        if (m_awvalid) begin
          if (aw_cnt >= aw_delay) begin m_awready = 1; aw_cnt = 0; end else aw_cnt++;
        end else aw_cnt = 0;
        if (m_wvalid) begin
          if (w_cnt >= w_delay) begin m_wready = 1; w_cnt = 0; end else w_cnt++;
        end else w_cnt = 0;
        if (m_arvalid) begin
          if (ar_cnt >= ar_delay) begin m_arready = 1; rd_addr = m_araddr; ar_cnt = 0; end else ar_cnt++;
        end else ar_cnt = 0;
        if (m_bready) begin
          if (b_cnt >= b_delay) begin m_bvalid = 1; m_bresp = bresp_v; b_cnt = 0; end else b_cnt++;
        end else b_cnt = 0;
        if (m_rready) begin
          if (r_cnt >= r_delay) begin
            m_rvalid = 1; m_rdata = rd_addr + 32'h1000; m_rresp = rresp_v; r_cnt = 0;
          end else r_cnt++;
        end else r_cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0, aw_cyc = 0, w_cyc = 0, overlap = 0, dual_ready = 0, fx_junk = 0, fx_rd_act = 0;
  int bhs [2];
  int rhs [2];
  int rhs_cyc [2];
  logic [31:0] aw_seen, w_seen;
  logic [3:0]  ws_seen;
  logic [2:0]  awp_seen;
  int gq[$];
  int gcyc[$];
  int q1[$];

  always @(negedge aclk) begin
    cyc++;
    if (aresetn) begin
      if (m_awvalid && m_wvalid) overlap++;
      if (m_awvalid && m_awready) begin aw_seen = m_awaddr; awp_seen = m_awprot; aw_cyc = cyc; end
      if (m_wvalid && m_wready) begin w_seen = m_wdata; ws_seen = m_wstrb; w_cyc = cyc; end
      if ((s_arready[0] | s_awready[0]) && (s_arready[1] | s_awready[1])) dual_ready++;
      for (int p = 0; p < 2; p++) begin
        if (s_bvalid[p] && b_ready[p]) bhs[p]++;
        if (s_rvalid[p] && r_ready[p]) begin rhs[p]++; rhs_cyc[p] = cyc; end
        if (s_arready[p] || s_awready[p]) begin gq.push_back(p); gcyc.push_back(cyc); end
        if (p_arready[p]) q1.push_back(p);
      end
      if (|{p_awready, p_wready, p_bvalid, p_bresp, p_rresp, p_rdata, p_m_awaddr, p_m_wdata,
            p_m_araddr, p_m_awprot, p_m_arprot, p_m_wstrb, p_m_awvalid, p_m_wvalid, p_m_bready})
        fx_junk++;
      if (|{p_rvalid, p_m_arvalid, p_m_rready}) fx_rd_act++;
    end
  end

  // ---------------- port drivers ----------------
  task automatic rd(input int p, input logic [31:0] a, output logic [31:0] d,
                    output logic [1:0] r, output bit to);
    int n;
    to = 0; d = '0; r = '0;
    ar_addr[p] = a; ar_prot[p] = 3'b001; ar_valid[p] = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_arready[p] && n < LIMIT) begin @(negedge aclk); n++; end
    if (!s_arready[p]) begin to = 1; ar_valid[p] = 1'b0; return; end
    @(posedge aclk); #1;
    ar_valid[p] = 1'b0; r_ready[p] = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_rvalid[p] && n < LIMIT) begin @(negedge aclk); n++; end
    if (!s_rvalid[p]) begin to = 1; r_ready[p] = 1'b0; return; end
    d = s_rdata[p]; r = s_rresp[p];
    @(posedge aclk); #1;
    r_ready[p] = 1'b0;
  endtask

  // AW is raised wlag cycles before W; early flags any ready seen meanwhile.
  task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int wlag, output logic [1:0] r, output bit early, output bit to);
    int n;
    to = 0; early = 0; r = '0;
    aw_addr[p] = a; aw_prot[p] = 3'b010; w_data[p] = d; w_strb[p] = s; aw_valid[p] = 1'b1;
    for (int i = 0; i < wlag; i++) begin
      @(negedge aclk);
      if (s_awready[p] || s_wready[p]) early = 1;
      @(posedge aclk); #1;
    end
    w_valid[p] = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_awready[p] && n < LIMIT) begin @(negedge aclk); n++; end
    if (!s_awready[p]) begin to = 1; aw_valid[p] = 1'b0; w_valid[p] = 1'b0; return; end
    @(posedge aclk); #1;
    aw_valid[p] = 1'b0; w_valid[p] = 1'b0; b_ready[p] = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_bvalid[p] && n < LIMIT) begin @(negedge aclk); n++; end
    if (!s_bvalid[p]) begin to = 1; b_ready[p] = 1'b0; return; end
    r = s_bresp[p];
    @(posedge aclk); #1;
    b_ready[p] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    ar_valid[0] = 1'b1; ar_addr[0] = 32'h44;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    total_cnt++;
    if ({s_arready, s_awready, s_wready} !== 6'd0)
      $display("FAIL reset_readies: got %b expected 000000", {s_arready, s_awready, s_wready});
    else pass_cnt++;
    total_cnt++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, s_bvalid, s_rvalid} !== 9'd0)
      $display("FAIL reset_valids: got %b expected 0", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, s_bvalid, s_rvalid});
    else pass_cnt++;
    total_cnt++;
    if ({m_awaddr, m_wdata, m_wstrb, s_rdata, s_bresp, s_rresp} !== '0)
      $display("FAIL reset_payload: got %h expected 0", {m_awaddr, m_wdata, m_wstrb});
    else pass_cnt++;
    ar_valid[0] = 1'b0;
    @(posedge aclk); #1 aresetn = 1'b1;
  endtask

  task automatic test_write();
    logic [1:0] r; bit e, to;
    bhs[0] = 0; bhs[1] = 0; overlap = 0; aw_cyc = 0; w_cyc = 0;
    aw_delay = 2; bresp_v = 2'b00;
    wr(0, 32'h0000_0204, 32'hDEAD_BEEF, 4'hF, 0, r, e, to);
    aw_delay = 0;
    repeat (3) @(posedge aclk); #1;
    total_cnt++;
    if (to) $display("FAIL wr_timeout: got timeout expected completion"); else pass_cnt++;
    total_cnt++;
    if (aw_seen !== 32'h0000_0204) $display("FAIL wr_awaddr: got %h expected 00000204", aw_seen); else pass_cnt++;
    total_cnt++;
    if (awp_seen !== 3'b010) $display("FAIL wr_awprot: got %b expected 010", awp_seen); else pass_cnt++;
    total_cnt++;
    if ({w_seen, ws_seen} !== {32'hDEAD_BEEF, 4'hF})
      $display("FAIL wr_wdata: got %h/%h expected deadbeef/f", w_seen, ws_seen);
    else pass_cnt++;
    total_cnt++;
    if (!(w_cyc > aw_cyc) || overlap != 0)
      $display("FAIL wr_aw_then_w: got aw@%0d w@%0d overlap %0d expected w after aw, overlap 0", aw_cyc, w_cyc, overlap);
    else pass_cnt++;
    total_cnt++;
    if (r !== 2'b00) $display("FAIL wr_bresp: got %b expected 00", r); else pass_cnt++;
    total_cnt++;
    if (bhs[0] != 1 || bhs[1] != 0)
      $display("FAIL wr_bvalid_count: got %0d/%0d expected 1/0", bhs[0], bhs[1]);
    else pass_cnt++;
  endtask

  task automatic test_dual_read();
    logic [31:0] d0, d1; logic [1:0] r0, r1; bit t0, t1;
    do_reset();
    gq.delete(); gcyc.delete(); rhs[0] = 0; rhs[1] = 0;
    fork
      rd(0, 32'h10, d0, r0, t0);
      rd(1, 32'h20, d1, r1, t1);
    join
    total_cnt++;
    if (gq.size() != 2 || gq[0] != 0 || gq[1] != 1)
      $display("FAIL dual_order: got size %0d first %0d expected 2 grants 0 then 1", gq.size(), (gq.size() > 0) ? gq[0] : -1);
    else pass_cnt++;
    total_cnt++;
    if (d0 !== 32'h1010 || r0 !== 2'b00 || t0) $display("FAIL dual_p0_data: got %h/%b expected 00001010/00", d0, r0); else pass_cnt++;
    total_cnt++;
    if (d1 !== 32'h1020 || r1 !== 2'b00 || t1) $display("FAIL dual_p1_data: got %h/%b expected 00001020/00", d1, r1); else pass_cnt++;
    total_cnt++;
    if (rhs[0] != 1 || rhs[1] != 1 || dual_ready != 0)
      $display("FAIL dual_rvalid_count: got %0d/%0d dual %0d expected 1/1 dual 0", rhs[0], rhs[1], dual_ready);
    else pass_cnt++;
  endtask

  task automatic test_alternate();
    logic [5:0] got; bit to0, to1;
    to0 = 0; to1 = 0;
    gq.delete(); gcyc.delete();
    fork
      begin
        logic [31:0] d; logic [1:0] r; bit t;
        for (int i = 0; i < 4; i++) begin rd(0, 32'h100 + 32'(i * 4), d, r, t); if (t) to0 = 1; end
      end
      begin
        logic [31:0] d; logic [1:0] r; bit t;
        for (int i = 0; i < 2; i++) begin rd(1, 32'h200 + 32'(i * 4), d, r, t); if (t) to1 = 1; end
      end
    join
    got = '0;
    for (int i = 0; i < 6 && i < gq.size(); i++) got[i] = gq[i][0];
    total_cnt++;
    if (gq.size() != 6 || to0 || to1) $display("FAIL alt_count: got %0d grants expected 6", gq.size()); else pass_cnt++;
    total_cnt++;
    if (got !== 6'b001010) $display("FAIL alt_order: got %b expected 001010 (lsb first)", got); else pass_cnt++;
  endtask

  task automatic test_prio_fixed();
    int ones;
    q1.delete(); fx_junk = 0; fx_rd_act = 0;
    @(posedge aclk); #1;
    p_rready = 2'b11; p_arvalid = 2'b11;
    repeat (40) @(posedge aclk); #1;
    ones = 0;
    foreach (q1[i]) if (q1[i] == 1) ones++;
    total_cnt++;
    if (q1.size() < 5 || ones != 0)
      $display("FAIL fx_starve: got %0d grants, %0d to port1 expected >=5, 0 to port1", q1.size(), ones);
    else pass_cnt++;
    p_arvalid[0] = 1'b0;
    repeat (10) @(posedge aclk); #1;
    ones = 0;
    foreach (q1[i]) if (q1[i] == 1) ones++;
    total_cnt++;
    if (ones == 0) $display("FAIL fx_port1_served: got 0 port1 grants expected at least 1"); else pass_cnt++;
    p_arvalid = 2'b00; p_rready = 2'b00;
    repeat (6) @(posedge aclk); #1;
    total_cnt++;
    if (fx_junk != 0 || fx_rd_act == 0)
      $display("FAIL fx_sideband: got junk %0d rd activity %0d expected 0 and nonzero", fx_junk, fx_rd_act);
    else pass_cnt++;
  endtask

  task automatic test_long_stall();
    logic [31:0] d1; logic [1:0] r1, rw; bit t1, tw, e;
    gq.delete(); gcyc.delete();
    r_delay = 5000; rresp_v = 2'b10; bresp_v = 2'b00;
    fork
      rd(1, 32'h300, d1, r1, t1);
      begin
        repeat (5) @(posedge aclk); #1;
        wr(0, 32'h0000_0400, 32'h1234_5678, 4'h3, 0, rw, e, tw);
      end
    join
    r_delay = 0; rresp_v = 2'b00;
    total_cnt++;
    if (t1 || tw) $display("FAIL stall_timeout: got timeout r=%0d w=%0d expected none", t1, tw); else pass_cnt++;
    total_cnt++;
    if (d1 !== 32'h1300 || r1 !== 2'b10) $display("FAIL stall_p1_resp: got %h/%b expected 00001300/10", d1, r1); else pass_cnt++;
    total_cnt++;
    if (gq.size() != 2 || gq[0] != 1 || gq[1] != 0)
      $display("FAIL stall_order: got %0d grants expected port1 then port0", gq.size());
    else pass_cnt++;
    total_cnt++;
    if (gq.size() != 2 || !(gcyc[1] > rhs_cyc[1]))
      $display("FAIL stall_p0_waited: got p0 grant cycle %0d p1 done %0d expected after", (gcyc.size() > 1) ? gcyc[1] : -1, rhs_cyc[1]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n, snap0, snap1; bit to, e; logic [1:0] r;
    b_delay = 10; to = 0;
    aw_addr[0] = 32'h600; aw_prot[0] = 3'b000; w_data[0] = 32'h1111_2222; w_strb[0] = 4'hF;
    aw_valid[0] = 1'b1; w_valid[0] = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_awready[0] && n < 50) begin @(negedge aclk); n++; end
    if (!s_awready[0]) to = 1;
    @(posedge aclk); #1;
    aw_valid[0] = 1'b0; w_valid[0] = 1'b0; b_ready[0] = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!m_bready && n < 50) begin @(negedge aclk); n++; end
    if (!m_bready) to = 1;
    snap0 = bhs[0]; snap1 = bhs[1];
    @(posedge aclk); #1 aresetn = 1'b0;
    @(posedge aclk); #1 aresetn = 1'b1;
    @(negedge aclk);
    total_cnt++;
    if (to || {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, s_bvalid, s_rvalid} !== 9'd0)
      $display("FAIL rstmid_outputs: got %b timeout %0d expected 0", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, s_bvalid, s_rvalid}, to);
    else pass_cnt++;
    repeat (20) @(negedge aclk);
    total_cnt++;
    if (bhs[0] != snap0 || bhs[1] != snap1)
      $display("FAIL rstmid_no_bvalid: got %0d/%0d expected %0d/%0d", bhs[0], bhs[1], snap0, snap1);
    else pass_cnt++;
    @(posedge aclk); #1;
    b_ready[0] = 1'b0; b_delay = 0; bresp_v = 2'b10;
    wr(0, 32'h604, 32'h3333_4444, 4'h1, 0, r, e, to);
    bresp_v = 2'b00;
    total_cnt++;
    if (to || r !== 2'b10) $display("FAIL rstmid_next_write: got bresp %b timeout %0d expected 10", r, to); else pass_cnt++;
    total_cnt++;
    if (bhs[0] != snap0 + 1) $display("FAIL rstmid_bcount: got %0d expected %0d", bhs[0], snap0 + 1); else pass_cnt++;
  endtask

  task automatic test_partial_write();
    logic [31:0] d; logic [1:0] r, rw; bit t, tw, e;
    gq.delete(); gcyc.delete();
    fork
      rd(0, 32'h40, d, r, t);
      wr(1, 32'h0000_0500, 32'hCAFE_F00D, 4'hC, 3, rw, e, tw);
    join
    total_cnt++;
    if (e) $display("FAIL partial_early_accept: got ready before wvalid expected none"); else pass_cnt++;
    total_cnt++;
    if (t || d !== 32'h1040 || r !== 2'b00) $display("FAIL partial_read: got %h/%b expected 00001040/00", d, r); else pass_cnt++;
    total_cnt++;
    if (gq.size() != 2 || gq[0] != 0 || gq[1] != 1)
      $display("FAIL partial_order: got %0d grants expected port0 read then port1 write", gq.size());
    else pass_cnt++;
    total_cnt++;
    if (tw || aw_seen !== 32'h500 || w_seen !== 32'hCAFE_F00D || ws_seen !== 4'hC || rw !== 2'b00)
      $display("FAIL partial_write: got %h/%h/%h expected 00000500/cafef00d/c", aw_seen, w_seen, ws_seen);
    else pass_cnt++;
  endtask

  initial begin
    aw_addr = '0; w_data = '0; ar_addr = '0; aw_prot = '0; ar_prot = '0; w_strb = '0;
    aw_valid = '0; w_valid = '0; b_ready = '0; ar_valid = '0; r_ready = '0;
    p_arvalid = '0; p_rready = '0;
    bhs[0] = 0; bhs[1] = 0; rhs[0] = 0; rhs[1] = 0; rhs_cyc[0] = 0; rhs_cyc[1] = 0;
    aw_seen = '0; w_seen = '0; ws_seen = '0; awp_seen = '0;
    test_reset();
    test_write();
    test_dual_read();
    test_alternate();
    test_prio_fixed();
    test_long_stall();
    test_reset_mid();
    test_partial_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
